// File: rtl/md_pkg.sv
// Shared encodings and latencies for the HI/LO multiply/divide resource.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP  = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_MTHI = 3'd3,
    MD_MTLO = 3'd4
  } md_func_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_LAT_MUL = 5;
  localparam int MD_LAT_DIV = 10;
  localparam int MD_CNT_W   = 4;

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {hi,lo} result for MUL/DIV, including div-by-zero and overflow cases.
module md_arith (
  input  logic        is_div_i,
  input  logic        sign_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic [63:0] a_ext, b_ext, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, divisor, uq, ur, q, r;

  always_comb begin
    a_ext   = sign_i ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
    b_ext   = sign_i ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
    // Low 64 bits of the extended product equal the true signed/unsigned product.
    prod    = a_ext * b_ext;

    neg_a   = sign_i & a_i[31];
    neg_b   = sign_i & b_i[31];
    mag_a   = neg_a ? -a_i : a_i;
    mag_b   = neg_b ? -b_i : b_i;
    divisor = (b_i == 32'd0) ? 32'd1 : mag_b;
    uq      = mag_a / divisor;
    ur      = mag_a % divisor;
    q       = (neg_a ^ neg_b) ? -uq : uq;
    r       = neg_a ? -ur : ur;

    if (!is_div_i)
      res_o = prod;
    else if (b_i == 32'd0)
      res_o = {a_i, 32'hFFFF_FFFF};
    else if (sign_i && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF)
      res_o = {32'd0, 32'h8000_0000};
    else
      res_o = {r, q};
  end

endmodule

// File: rtl/md_unit_sequencer.sv
// EX-stage HI/LO sequencer: fixed-latency MUL/DIV, immediate MTHI/MTLO, stall toward IF/ID.
module md_unit_sequencer
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_LAT_MUL,
  parameter int DIV_LAT = MD_LAT_DIV,
  parameter int CNT_W   = MD_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_start,
  input  logic        ex_flush,
  input  logic [2:0]  md_func,
  input  logic        md_sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        id_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  md_func_e         func;
  logic             accept;
  logic [63:0]      arith_res;

  assign func   = md_func_e'(md_func);
  assign accept = ex_start & ~ex_flush & (state_q == MD_IDLE);

  md_arith u_arith (
    .is_div_i (func == MD_DIV),
    .sign_i   (md_sign),
    .a_i      (op_a),
    .b_i      (op_b),
    .res_o    (arith_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          case (func)
            MD_MUL: begin
              pend_d  = arith_res;
              cnt_d   = MUL_CNT;
              state_d = MD_BUSY;
            end
            MD_DIV: begin
              pend_d  = arith_res;
              cnt_d   = DIV_CNT;
              state_d = MD_BUSY;
            end
            MD_MTHI: hi_d = op_a;
            MD_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = pend_q;
          state_d      = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == MD_BUSY);
  assign stall = busy & id_uses_md;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
